ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Execute-stage ALU block for the WISC pipeline. It consumes the 7-bit ALU control word and `condition` flag produced by decode, together with the two register operands. It computes arithmetic, logic, set-condition and shift/rotate results and holds them in an output register for the EX/MEM boundary. Shifts and rotates run iteratively, one bit per cycle, so the block exerts backpressure on decode through a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 16: datapath width.
- `SHAMT_W`, 4: shift-amount width, taken from `op_b[SHAMT_W-1:0]`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: decode presents an operation.
- `in_ready`, output, 1: the block accepts an operation this cycle.
- `alu_ctrl`, input, 7: [2:0] op, [3] invA, [4] invB, [5] signed, [6] Cin.
- `condition`, input, 1: the operation is a set instruction (SEQ/SLT/SLE/SCO).
- `set_sel`, input, 2: opcode[1:0] of a set instruction: 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
- `op_a`, `op_b`, input, WIDTH: operands.
- `dest`, input, 3: destination register tag, passed through.
- `flush`, input, 1: synchronous squash.
- `out_valid`, output, 1: the result is held.
- `out_ready`, input, 1: the downstream stage consumes the result.
- `out_result`, output, WIDTH: the result.
- `out_dest`, output, 3: registered `dest`.

## Operation
Operand conditioning:
- A' = invA ? ~op_a : op_a.
- B' = invB ? ~op_b : op_b.
- The sum is computed (WIDTH+1) bits wide: A' + B' + Cin.

Op encoding (`alu_ctrl[2:0]`):
- 100 ADD (SUB when invA=Cin=1, giving B−A).
- 101 OR.
- 110 XOR.
- 111 AND (ANDN when invB=1).
- 000 ROL, 001 SLL, 010 ROR, 011 SRL.
- Shifts and rotates operate on op_a by amt = op_b[3:0]. Vacated bits are filled with 0.

Set instructions (`condition`=1) override the op result with a zero-extended 0/1:
- Z = sum[WIDTH-1:0]==0.
- N = sum[WIDTH-1].
- V = signed overflow of A'+B'+Cin. V is meaningful only when `alu_ctrl[5]`=1; otherwise it is treated as 0.
- SEQ: Z.
- SLT (A<B): ~(N^V) & ~Z.
- SLE: ~(N^V).
- SCO: carry out, sum[WIDTH].

FSM states:
- IDLE: `in_ready` = ~out_valid | out_ready. When `in_valid` & `in_ready`:
  - Non-shift, or shift with amt=0: load the result into the output register, set `out_valid`, stay in IDLE.
  - Shift with amt>0: latch op_a, op, amt and dest into a working register; go to SHIFT. If `out_ready` is also asserted, the old `out_valid` clears.
- SHIFT: `in_ready`=0. Each cycle, shift or rotate the working register by 1 and decrement the count.
  - On the cycle the count reaches 0, write the result to the output register with `out_valid`=1.
  - If the output register is still full (out_valid & ~out_ready), hold the final value and wait. Then return to IDLE.

Output register:
- Holds its value until `out_ready`.
- `out_valid` drops on the cycle after consumption, unless a new result is loaded in the same cycle.

## Timing
Reset (async, rst_n=0):
- State IDLE.
- `out_valid`=0, `out_result`=0, `out_dest`=0.
- Working count 0.
- `in_ready`=1 once reset is released.

Latency:
- Accept at edge T, non-shift: `out_valid` high after edge T+1 (1 cycle).
- Shift with amt=k: `out_valid` high after edge T+1+k.

Flush (synchronous, highest priority):
- Next state IDLE, `out_valid`=0, the working shift is aborted.
- An operation offered in the same cycle is dropped.
- `in_ready` still reflects the pre-flush state combinationally.

Simultaneous events:
- `out_ready` and a new accept in the same cycle are back-to-back: `out_valid` stays 1 with the new data.
- Reset mid-SHIFT discards the operation and produces no output.

Arithmetic:
- Carry out is taken from bit WIDTH of the sum.
- Results wrap modulo 2^WIDTH.

## Test plan
- ADD 0x7FFF+0x0001, ctrl=0000100 → `out_result`=0x8000 one cycle after accept; SCO (`condition`=1, `set_sel`=11) on 0xFFFF+0x0001 → 0x0001.
- SUB via ctrl=1101100 with A=5, B=3: SLT → 0, SLE → 0, SEQ → 0. With A=B=0x8000: SEQ → 1, SLE → 1. With A=0x8000, B=0x7FFF, signed: SLT → 1 (overflow path).
- ROL op_a=0x8001, amt=4 → `in_ready`=0 for 4 cycles, `out_result`=0x0018 at T+5. SRL 0x8000 by 15 → 0x0001. SLL with amt=0 → 1-cycle latency, operand unchanged.
- Hold `out_ready`=0 with `out_valid`=1: `in_ready`=0, a completing shift stalls in SHIFT with its result preserved. Raising `out_ready` delivers the old then the new result, with no loss or duplication.
- `flush` asserted mid-SHIFT (amt=8, cycle 3) → `out_valid` stays 0, state IDLE, the next ADD completes normally in 1 cycle.
- Deassert `rst_n` asynchronously mid-SHIFT with `out_valid`=1 → `out_valid`, `out_result` and `out_dest` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: WISC execute-stage ALU. Single-cycle arithmetic/logic/set ops,
// and iterative one-bit-per-cycle shifts/rotates with a valid/ready handshake.
module ex_alu_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         alu_ctrl,
  input  logic               condition,
  input  logic [1:0]         set_sel,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [2:0]         dest,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [2:0]         out_dest
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_work;
  logic [1:0]         r_sop;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2:0]         r_wdest;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_result;
  logic [2:0]         r_out_dest;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic               w_z;
  logic               w_n;
  logic               w_v;
  logic               w_set;
  logic [WIDTH-1:0]   w_imm;
  logic [SHAMT_W-1:0] w_amt;
  logic               w_shift_start;
  logic [WIDTH-1:0]   w_step;
  logic               w_out_free;
  logic               w_accept;
  logic               w_done;
  logic               w_load;
  logic [WIDTH-1:0]   w_load_data;
  logic [2:0]         w_load_dest;

  // Operand conditioning, adder, flags and the single-cycle result
  always_comb begin
    w_a   = alu_ctrl[3] ? ~op_a : op_a;
    w_b   = alu_ctrl[4] ? ~op_b : op_b;
    w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, alu_ctrl[6]};
    w_z   = (w_sum[WIDTH-1:0] == '0);
    w_n   = w_sum[WIDTH-1];
    w_v   = alu_ctrl[5] & (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    unique case (set_sel)
      2'b00:   w_set = w_z;
      2'b01:   w_set = ~(w_n ^ w_v) & ~w_z;
      2'b10:   w_set = ~(w_n ^ w_v);
      default: w_set = w_sum[WIDTH];
    endcase
    unique case (alu_ctrl[2:0])
      3'b100:  w_imm = w_sum[WIDTH-1:0];
      3'b101:  w_imm = w_a | w_b;
      3'b110:  w_imm = w_a ^ w_b;
      3'b111:  w_imm = w_a & w_b;
      default: w_imm = op_a;  // shift/rotate by zero: operand unchanged
    endcase
    if (condition) begin
      w_imm = {{(WIDTH-1){1'b0}}, w_set};
    end
    w_amt         = op_b[SHAMT_W-1:0];
    w_shift_start = ~alu_ctrl[2] & ~condition & (w_amt != '0);
  end

  // One-bit step of the working register for the latched shift kind
  always_comb begin
    unique case (r_sop)
      2'b00:   w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      2'b01:   w_step = {r_work[WIDTH-2:0], 1'b0};
      2'b10:   w_step = {r_work[0], r_work[WIDTH-1:1]};
      default: w_step = {1'b0, r_work[WIDTH-1:1]};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept && w_shift_start) w_state_nxt = SHIFT;
        default: if (w_done && w_out_free)      w_state_nxt = IDLE;
      endcase
    end
  end

  // Handshake and output-register load control.
  // The last shift step is written straight to the output register so a
  // shift by k completes k cycles after acceptance; a count of zero in SHIFT
  // means the final value is parked in r_work waiting for space.
  always_comb begin
    w_out_free  = ~r_out_valid | out_ready;
    in_ready    = (r_state == IDLE) & w_out_free;
    w_accept    = in_valid & in_ready & ~flush;
    w_done      = (r_cnt == CNT_ONE) | (r_cnt == '0);
    w_load      = 1'b0;
    w_load_data = w_imm;
    w_load_dest = dest;
    unique case (r_state)
      IDLE: w_load = w_accept & ~w_shift_start;
      default: begin
        w_load      = w_done & w_out_free & ~flush;
        w_load_data = (r_cnt == '0) ? r_work : w_step;
        w_load_dest = r_wdest;
      end
    endcase
  end

  // Working shift register and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_sop   <= '0;
      r_cnt   <= '0;
      r_wdest <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept && w_shift_start) begin
        r_work  <= op_a;
        r_sop   <= alu_ctrl[1:0];
        r_cnt   <= w_amt;
        r_wdest <= dest;
      end
    end else if (r_cnt != '0) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end

  // EX/MEM output register: holds until consumed, reloads back-to-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_dest   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_load_data;
      r_out_dest   <= w_load_dest;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_dest   = r_out_dest;

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed scenarios plus randomized traffic scored against
// an arithmetic reference model of the execute-stage ALU.
module tb_ex_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  alu_ctrl;
  logic        condition;
  logic [1:0]  set_sel;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  dest;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  d;
  } exp_t;
  exp_t q[$];

  ex_alu_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .condition(condition), .set_sel(set_sel),
    .op_a(op_a), .op_b(op_b), .dest(dest), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on conditioned operands
  function automatic logic [15:0] model(input logic [6:0] c, input logic cond,
                                        input logic [1:0] sel, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] ta, tb;
    int unsigned s, ua, ub, k;
    int sa, sb, ss;
    bit z, n, v, co, res;
    ta = c[3] ? ~a : a;
    tb = c[4] ? ~b : b;
    ua = ta; ub = tb;
    s  = ua + ub + c[6];
    if (cond) begin
      z  = (s % 65536) == 0;
      n  = ((s >> 15) & 1) == 1;
      co = ((s >> 16) & 1) == 1;
      sa = int'($signed(ta));
      sb = int'($signed(tb));
      ss = sa + sb + int'(c[6]);
      v  = c[5] && (ss > 32767 || ss < -32768);
      case (sel)
        2'b00: res = z;
        2'b01: res = (n == v) && !z;
        2'b10: res = (n == v);
        default: res = co;
      endcase
      return res ? 16'd1 : 16'd0;
    end
    ua = a;
    k  = b[3:0];
    case (c[2:0])
      3'b100: return 16'(s);
      3'b101: return ta | tb;
      3'b110: return ta ^ tb;
      3'b111: return ta & tb;
      3'b000: return 16'((ua << k) | (ua >> (16 - k)));
      3'b001: return 16'(ua << k);
      3'b010: return 16'((ua >> k) | (ua << (16 - k)));
      default: return 16'(ua >> k);
    endcase
  endfunction

  // Scoreboard: sampled mid-cycle, handshakes complete at the next rising edge
  always @(negedge clk) begin
    if (rst_n && sb_on) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          chk("sb_result", out_result, q[0].r);
          chk("sb_dest", out_dest, q[0].d);
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready && !flush)
        q.push_back('{r: model(alu_ctrl, condition, set_sel, op_a, op_b), d: dest});
    end
  end

  task automatic set_op(input logic [6:0] c, input logic cond, input logic [1:0] sel,
                        input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
    alu_ctrl = c; condition = cond; set_sel = sel; op_a = a; op_b = b; dest = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Issue one op with an empty output register and measure its latency
  task automatic run_op(input string tag, input logic [6:0] c, input logic cond,
                        input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d, input logic [15:0] exp, input int exp_lat);
    int lat;
    bit irbad;
    chk({tag, "_inready"}, in_ready, 1);
    set_op(c, cond, sel, a, b, d);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    lat = 1; irbad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) irbad = 1;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_dest"}, out_dest, d);
    if (exp_lat > 1) chk({tag, "_busy"}, irbad, 0);
    tick();
  endtask

  initial begin
    bit bad;
    int guard;
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 1;
    set_op(7'd0, 0, 2'd0, 16'd0, 16'd0, 3'd0);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_dest", out_dest, 0);
    #21 rst_n = 1;
    tick();
    chk("rst_inready", in_ready, 1);

    // Arithmetic and set operations
    run_op("add",    7'b0000100, 0, 2'b00, 16'h7FFF, 16'h0001, 3'd1, 16'h8000, 1);
    run_op("sco",    7'b0000100, 1, 2'b11, 16'hFFFF, 16'h0001, 3'd2, 16'h0001, 1);
    run_op("slt53",  7'b1101100, 1, 2'b01, 16'h0005, 16'h0003, 3'd3, 16'h0000, 1);
    run_op("sle53",  7'b1101100, 1, 2'b10, 16'h0005, 16'h0003, 3'd3, 16'h0000, 1);
    run_op("seq53",  7'b1101100, 1, 2'b00, 16'h0005, 16'h0003, 3'd3, 16'h0000, 1);
    run_op("seq88",  7'b1101100, 1, 2'b00, 16'h8000, 16'h8000, 3'd4, 16'h0001, 1);
    run_op("sle88",  7'b1101100, 1, 2'b10, 16'h8000, 16'h8000, 3'd4, 16'h0001, 1);
    run_op("slt_ov", 7'b1101100, 1, 2'b01, 16'h8000, 16'h7FFF, 3'd5, 16'h0001, 1);
    run_op("andn",   7'b0010111, 0, 2'b00, 16'hF0F0, 16'h00FF, 3'd6, 16'hF000, 1);

    // Shifts and rotates
    run_op("rol4",   7'b0000000, 0, 2'b00, 16'h8001, 16'h0004, 3'd7, 16'h0018, 5);
    run_op("srl15",  7'b0000011, 0, 2'b00, 16'h8000, 16'h000F, 3'd1, 16'h0001, 16);
    run_op("sll0",   7'b0000001, 0, 2'b00, 16'hABCD, 16'h0000, 3'd2, 16'hABCD, 1);
    run_op("ror1",   7'b0000010, 0, 2'b00, 16'h0001, 16'h0001, 3'd3, 16'h8000, 2);

    // Backpressure: full output blocks acceptance, then old and new results in order
    out_ready = 0;
    set_op(7'b0000100, 0, 2'b00, 16'h1234, 16'h0101, 3'd5);
    in_valid = 1;
    tick();
    chk("bp_valid", out_valid, 1);
    set_op(7'b0000011, 0, 2'b00, 16'hF000, 16'h0003, 3'd6);
    chk("bp_inready", in_ready, 0);
    repeat (3) tick();
    chk("bp_hold_res", out_result, 16'h1335);
    chk("bp_hold_dest", out_dest, 5);
    chk("bp_hold_inready", in_ready, 0);
    out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    chk("bp_consumed", out_valid, 0);
    repeat (3) tick();
    chk("bp_shift_valid", out_valid, 1);
    chk("bp_shift_res", out_result, 16'h1E00);
    chk("bp_shift_dest", out_dest, 6);
    repeat (2) tick();
    chk("bp_stall_res", out_result, 16'h1E00);
    chk("bp_stall_valid", out_valid, 1);
    out_ready = 1;
    tick();
    chk("bp_drained", out_valid, 0);

    // Flush mid-shift
    set_op(7'b0000010, 0, 2'b00, 16'h00FF, 16'h0008, 3'd4);
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    bad = 0;
    repeat (12) begin
      if (out_valid) bad = 1;
      tick();
    end
    chk("flush_novalid", bad, 0);
    run_op("post_flush", 7'b0000100, 0, 2'b00, 16'h0002, 16'h0003, 3'd1, 16'h0005, 1);

    // Flush drops an op offered in the same cycle
    set_op(7'b0000100, 0, 2'b00, 16'h0001, 16'h0001, 3'd2);
    in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    chk("flush_drop", out_valid, 0);

    // Asynchronous reset with a held result
    out_ready = 0;
    set_op(7'b0000100, 0, 2'b00, 16'h0001, 16'h0002, 3'd7);
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("arst_pre_valid", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_dest", out_dest, 0);
    tick();
    rst_n = 1;
    out_ready = 1;

    // Asynchronous reset mid-shift produces no output
    set_op(7'b0000001, 0, 2'b00, 16'h0001, 16'h000A, 3'd3);
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (3) tick();
    #1 rst_n = 0;
    #1;
    chk("arst_shift_inready", in_ready, 1);
    tick();
    rst_n = 1;
    bad = 0;
    repeat (15) begin
      if (out_valid) bad = 1;
      tick();
    end
    chk("arst_shift_noout", bad, 0);

    // Randomized traffic with random backpressure
    sb_on = 1;
    for (int i = 0; i < 400; i++) begin
      logic [6:0] c;
      logic cd;
      c  = 7'($urandom);
      cd = ($urandom_range(0, 3) == 0);
      if (cd) c[2] = 1'b1;
      set_op(c, cd, 2'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 0; out_ready = 1;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 40) begin
      tick();
      guard++;
    end
    chk("rand_drain", q.size(), 0);
    sb_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
